firebird7_in_gate1_tessent_data_mux_sync: RTL and testbench
===========================================================

# firebird7_in_gate1_tessent_data_mux_sync

Parametrised, multi-channel successor to the gate1 IJTAG data mux. Each channel steers either functional data or IJTAG data onto its output, like the combinational mux. Switchover is no longer instantaneous: a per-channel state machine holds the last driven value for a programmable settle window whenever the select changes, so downstream logic never sees a mixed or glitching word. The block sits between the gate1 TDR select/data registers and the functional consumers, clocked by the IJTAG clock.

## Interface
- WIDTH, 19: data bits per channel (≥1).
- NUM_CH, 1: number of independent channels (≥1).
- SETTLE_CYCLES, 2: hold-window length in clocks (0–255; 0 disables hold).
- ijtag_tck  input  1  clock, rising-edge.
- ijtag_reset  input  1  asynchronous, active-low reset.
- ijtag_select  input  NUM_CH  per-channel source select (1 = IJTAG).
- functional_data_in  input  NUM_CH*WIDTH  functional data; channel c at bits [c*WIDTH +: WIDTH].
- ijtag_data_in  input  NUM_CH*WIDTH  IJTAG data, same packing.
- data_out  output  NUM_CH*WIDTH  steered data, same packing.
- ijtag_active  output  NUM_CH  channel c is in state IJTAG.
- switch_busy  output  NUM_CH  channel c is in a hold state.

## Operation
- Channels are fully independent; all rules below apply per channel.
- States: FUNC, HOLD_TO_IJ, IJTAG, HOLD_TO_FN. Reset state FUNC, counter 0, hold register 0.
- data_out source by state: FUNC → functional_data_in, combinational; IJTAG → ijtag_data_in, combinational; HOLD_* → hold register.
- Hold register loads data_out on every clock while in FUNC or IJTAG. It is frozen in HOLD_*.
- FUNC with select=1: if SETTLE_CYCLES=0, go to IJTAG; otherwise go to HOLD_TO_IJ and load the counter with SETTLE_CYCLES-1.
- IJTAG with select=0: mirror of the FUNC rule, going to FUNC or HOLD_TO_FN.
- HOLD_TO_IJ:
  - select=1 and counter=0 → IJTAG.
  - select=1 and counter≠0 → decrement the counter.
  - select=0 (reversal) → HOLD_TO_FN with the counter reloaded to SETTLE_CYCLES-1. The hold value is unchanged.
- HOLD_TO_FN: mirror of HOLD_TO_IJ.
- The counter width is $clog2(SETTLE_CYCLES+1), minimum 1. It never wraps: it only decrements from a nonzero value.
- ijtag_active = (state==IJTAG). switch_busy = state is HOLD_TO_IJ or HOLD_TO_FN. Both are registered decodes of the state.
- Reset values (asynchronous, immediate): ijtag_active=0, switch_busy=0, data_out = functional_data_in (combinational, state FUNC).
- Reset asserted mid-hold or in IJTAG returns the channel to FUNC immediately. The hold register clears. After deassertion the first sampled select is treated as a new request.

## Timing
- Steady-state data path: 0-cycle combinational latency, same as the previous mux.
- Select is sampled on the rising edge of ijtag_tck. The output source changes only on a clock edge, never combinationally from ijtag_select.
- A select edge sampled at edge N has two cases:
  - SETTLE_CYCLES=0: new source from edge N.
  - SETTLE_CYCLES=S>0: hold value driven from edge N through edge N+S; new source from edge N+S.
- switch_busy is high for exactly S cycles per uninterrupted switch.
- A reversal at edge M restarts the window: the new source arrives at edge M+S.
- The hold value equals data_out in the cycle before edge N.

## Test plan
- Reset: hold ijtag_reset=0, drive functional=0x1_2345 and ijtag=0x7_FFFF with select=1 → data_out=0x1_2345, ijtag_active=0, switch_busy=0.
- Basic switch, S=2: functional=0x0_00AA, ijtag=0x5_5555, raise select before edge N.
  - Edges N and N+1: data_out=0x0_00AA; vary functional during these cycles → output unchanged.
  - Edge N+2: data_out=0x5_5555 and ijtag_active=1. switch_busy is high for 2 cycles.
- Reversal, S=3: raise select, then drop it after 1 cycle of hold → switch_busy stays high for 4 cycles total, ijtag_active never rises, output then returns to functional.
- S=0: toggle select every cycle → data_out follows the selected source one edge later with no hold, and switch_busy is never asserted.
- Multi-channel, NUM_CH=3: switch only channel 1 → channels 0 and 2 track functional combinationally; ijtag_active=3'b010 after settle.
- Reset mid-hold: assert ijtag_reset during HOLD_TO_IJ → immediate FUNC, switch_busy=0. After release with select=1, a full S-cycle hold with hold value 0x0 precedes IJTAG.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync_if.sv
// Bundles the per-channel select, the two data sources and the steered outputs of the
// gate1 settle-window data mux.
interface firebird7_in_gate1_tessent_data_mux_sync_if #(
  parameter int unsigned WIDTH  = 19,
  parameter int unsigned NUM_CH = 1
);
  logic [NUM_CH-1:0]       ijtag_select;
  logic [NUM_CH*WIDTH-1:0] functional_data_in;
  logic [NUM_CH*WIDTH-1:0] ijtag_data_in;
  logic [NUM_CH*WIDTH-1:0] data_out;
  logic [NUM_CH-1:0]       ijtag_active;
  logic [NUM_CH-1:0]       switch_busy;

  modport master (
    output ijtag_select,
    output functional_data_in,
    output ijtag_data_in,
    input  data_out,
    input  ijtag_active,
    input  switch_busy
  );

  modport slave (
    input  ijtag_select,
    input  functional_data_in,
    input  ijtag_data_in,
    output data_out,
    output ijtag_active,
    output switch_busy
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync.sv
// Multi-channel functional/IJTAG data mux; each channel freezes its last driven word for a
// programmable settle window whenever its select changes, so consumers never see a mixed word.
module firebird7_in_gate1_tessent_data_mux_sync #(
  parameter int unsigned WIDTH         = 19,
  parameter int unsigned NUM_CH        = 1,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic ijtag_tck,
  input logic ijtag_reset,
  firebird7_in_gate1_tessent_data_mux_sync_if.slave bus
);

  localparam int unsigned CntW      = (SETTLE_CYCLES == 0) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned ReloadInt = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
  localparam logic [CntW-1:0] Reload = CntW'(ReloadInt);
  localparam bit NoHold = (SETTLE_CYCLES == 0);

  typedef enum logic [1:0] {
    StFunc,
    StHoldToIj,
    StIjtag,
    StHoldToFn
  } state_e;

  state_e state_q [NUM_CH];
  state_e state_d [NUM_CH];

  logic [NUM_CH-1:0][CntW-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0][WIDTH-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0][WIDTH-1:0] func_w, ij_w, dout_w;
  logic [NUM_CH-1:0]            sel_w;
  logic [NUM_CH-1:0]            active_q, active_d, busy_q, busy_d;

  assign func_w           = bus.functional_data_in;
  assign ij_w             = bus.ijtag_data_in;
  assign sel_w            = bus.ijtag_select;
  assign bus.data_out     = dout_w;
  assign bus.ijtag_active = active_q;
  assign bus.switch_busy  = busy_q;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      hold_d[c]  = hold_q[c];
      dout_w[c]  = func_w[c];
      unique case (state_q[c])
        StFunc: begin
          dout_w[c] = func_w[c];
          hold_d[c] = func_w[c];
          if (sel_w[c]) begin
            state_d[c] = NoHold ? StIjtag : StHoldToIj;
            cnt_d[c]   = Reload;
          end
        end
        StIjtag: begin
          dout_w[c] = ij_w[c];
          hold_d[c] = ij_w[c];
          if (!sel_w[c]) begin
            state_d[c] = NoHold ? StFunc : StHoldToFn;
            cnt_d[c]   = Reload;
          end
        end
        StHoldToIj: begin
          dout_w[c] = hold_q[c];
          // A reversal restarts the full window towards the other source.
          if (!sel_w[c]) begin
            state_d[c] = StHoldToFn;
            cnt_d[c]   = Reload;
          end else if (cnt_q[c] == '0) begin
            state_d[c] = StIjtag;
          end else begin
            cnt_d[c] = cnt_q[c] - CntW'(1);
          end
        end
        StHoldToFn: begin
          dout_w[c] = hold_q[c];
          if (sel_w[c]) begin
            state_d[c] = StHoldToIj;
            cnt_d[c]   = Reload;
          end else if (cnt_q[c] == '0) begin
            state_d[c] = StFunc;
          end else begin
            cnt_d[c] = cnt_q[c] - CntW'(1);
          end
        end
        default: state_d[c] = StFunc;
      endcase
      active_d[c] = (state_d[c] == StIjtag);
      busy_d[c]   = (state_d[c] == StHoldToIj) || (state_d[c] == StHoldToFn);
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= StFunc;
      end
      cnt_q    <= '0;
      hold_q   <= '0;
      active_q <= '0;
      busy_q   <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
      end
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      active_q <= active_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_sync.sv
// Bench for the settle-window data mux: three configurations (S=2/1ch, S=3/3ch, S=0/1ch)
// driven in lockstep and compared with a source/window reference model.
module tb_firebird7_in_gate1_tessent_data_mux_sync;
  localparam int unsigned W = 19;

  logic ijtag_tck   = 1'b0;
  logic ijtag_reset = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  firebird7_in_gate1_tessent_data_mux_sync_if #(.WIDTH(W), .NUM_CH(1)) if_a ();
  firebird7_in_gate1_tessent_data_mux_sync_if #(.WIDTH(W), .NUM_CH(3)) if_b ();
  firebird7_in_gate1_tessent_data_mux_sync_if #(.WIDTH(W), .NUM_CH(1)) if_c ();

  firebird7_in_gate1_tessent_data_mux_sync #(.WIDTH(W), .NUM_CH(1), .SETTLE_CYCLES(2)) dut_a (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .bus        (if_a)
  );
  firebird7_in_gate1_tessent_data_mux_sync #(.WIDTH(W), .NUM_CH(3), .SETTLE_CYCLES(3)) dut_b (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .bus        (if_b)
  );
  firebird7_in_gate1_tessent_data_mux_sync #(.WIDTH(W), .NUM_CH(1), .SETTLE_CYCLES(0)) dut_c (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .bus        (if_c)
  );

  int checks = 0;
  int errors = 0;

  int unsigned s_cfg [3] = '{2, 3, 0};
  int unsigned nch   [3] = '{1, 3, 1};

  // Stimulus values and reference model: current source, pending target, window cycles left.
  logic         m_sel  [3][3];
  logic [W-1:0] m_func [3][3];
  logic [W-1:0] m_ij   [3][3];
  bit           m_src  [3][3];
  bit           m_tgt  [3][3];
  int unsigned  m_left [3][3];
  logic [W-1:0] m_held [3][3];

  function automatic logic [W-1:0] model_out(int d, int c);
    if (m_left[d][c] != 0) return m_held[d][c];
    return m_src[d][c] ? m_ij[d][c] : m_func[d][c];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 3; c++) begin
        m_src[d][c]  = 1'b0;
        m_tgt[d][c]  = 1'b0;
        m_left[d][c] = 0;
        m_held[d][c] = '0;
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < int'(nch[d]); c++) begin
        logic [W-1:0] prev;
        prev = model_out(d, c);
        if (m_left[d][c] == 0) begin
          if (m_sel[d][c] != m_src[d][c]) begin
            if (s_cfg[d] == 0) begin
              m_src[d][c] = m_sel[d][c];
            end else begin
              m_left[d][c] = s_cfg[d];
              m_tgt[d][c]  = m_sel[d][c];
              m_held[d][c] = prev;
            end
          end
        end else if (m_sel[d][c] != m_tgt[d][c]) begin
          m_tgt[d][c]  = m_sel[d][c];
          m_left[d][c] = s_cfg[d];
        end else begin
          m_left[d][c] = m_left[d][c] - 1;
          if (m_left[d][c] == 0) m_src[d][c] = m_tgt[d][c];
        end
      end
    end
  endtask

  task automatic drive();
    if_a.ijtag_select       = m_sel[0][0];
    if_a.functional_data_in = m_func[0][0];
    if_a.ijtag_data_in      = m_ij[0][0];
    for (int c = 0; c < 3; c++) begin
      if_b.ijtag_select[c]               = m_sel[1][c];
      if_b.functional_data_in[c*W +: W]  = m_func[1][c];
      if_b.ijtag_data_in[c*W +: W]       = m_ij[1][c];
    end
    if_c.ijtag_select       = m_sel[2][0];
    if_c.functional_data_in = m_func[2][0];
    if_c.ijtag_data_in      = m_ij[2][0];
  endtask

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < int'(nch[d]); c++) begin
        logic [W-1:0] o;
        logic a, b;
        case (d)
          0: begin o = if_a.data_out; a = if_a.ijtag_active[0]; b = if_a.switch_busy[0]; end
          1: begin
            o = if_b.data_out[c*W +: W];
            a = if_b.ijtag_active[c];
            b = if_b.switch_busy[c];
          end
          default: begin o = if_c.data_out; a = if_c.ijtag_active[0]; b = if_c.switch_busy[0]; end
        endcase
        check($sformatf("d%0d.c%0d.data_out", d, c), o, model_out(d, c));
        check($sformatf("d%0d.c%0d.ijtag_active", d, c), W'(a),
              W'(m_left[d][c] == 0 && m_src[d][c]));
        check($sformatf("d%0d.c%0d.switch_busy", d, c), W'(b), W'(m_left[d][c] != 0));
      end
    end
  endtask

  task automatic apply();
    drive();
    #1;
    check_all();
  endtask

  task automatic cycle();
    @(posedge ijtag_tck);
    if (ijtag_reset) model_step();
    #1;
    check_all();
  endtask

  initial begin
    int busy_n;
    bit act_seen;

    // Reset with select raised: outputs must still be the functional word.
    model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 3; c++) begin
        m_sel[d][c]  = 1'b1;
        m_func[d][c] = 19'h1_2345;
        m_ij[d][c]   = 19'h7_FFFF;
      end
    end
    apply();
    check("reset.data_out", if_a.data_out, 19'h1_2345);
    check("reset.ijtag_active", W'(if_a.ijtag_active), '0);
    check("reset.switch_busy", W'(if_a.switch_busy), '0);
    cycle();
    check("reset.clocked.data_out", if_a.data_out, 19'h1_2345);
    for (int d = 0; d < 3; d++) for (int c = 0; c < 3; c++) m_sel[d][c] = 1'b0;
    apply();
    ijtag_reset = 1'b1;
    #1;
    check_all();

    // Basic switch, S=2.
    m_func[0][0] = 19'h0_00AA;
    m_ij[0][0]   = 19'h5_5555;
    m_sel[0][0]  = 1'b1;
    apply();
    busy_n = 0;
    cycle();
    busy_n += int'(if_a.switch_busy[0]);
    m_func[0][0] = W'($urandom);
    apply();
    check("basic.edge_n.data_out", if_a.data_out, 19'h0_00AA);
    cycle();
    busy_n += int'(if_a.switch_busy[0]);
    check("basic.edge_n1.data_out", if_a.data_out, 19'h0_00AA);
    m_func[0][0] = W'($urandom);
    apply();
    cycle();
    busy_n += int'(if_a.switch_busy[0]);
    check("basic.edge_n2.data_out", if_a.data_out, 19'h5_5555);
    check("basic.edge_n2.ijtag_active", W'(if_a.ijtag_active), W'(1));
    check("basic.busy_cycles", W'(busy_n), W'(2));

    // Reversal after one hold cycle, S=3, channel 1 only.
    m_sel[1][1] = 1'b1;
    apply();
    cycle();
    busy_n   = int'(if_b.switch_busy[1]);
    act_seen = if_b.ijtag_active[1];
    m_sel[1][1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_func[1][0] = W'($urandom);
      m_func[1][1] = W'($urandom);
      m_func[1][2] = W'($urandom);
      apply();
      cycle();
      busy_n += int'(if_b.switch_busy[1]);
      act_seen |= if_b.ijtag_active[1];
    end
    check("reversal.busy_cycles", W'(busy_n), W'(4));
    check("reversal.active_seen", W'(act_seen), '0);
    check("reversal.data_out", if_b.data_out[W +: W], m_func[1][1]);

    // Multi-channel: full switch of channel 1 only.
    m_sel[1][1] = 1'b1;
    apply();
    for (int i = 0; i < 4; i++) begin
      m_func[1][0] = W'($urandom);
      m_func[1][2] = W'($urandom);
      apply();
      cycle();
    end
    check("multi.ijtag_active", W'(if_b.ijtag_active), W'(3'b010));
    check("multi.ch2.data_out", if_b.data_out[2*W +: W], m_func[1][2]);

    // S=0: toggle every cycle, never busy.
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      m_sel[2][0]  = ~m_sel[2][0];
      m_func[2][0] = W'($urandom);
      m_ij[2][0]   = W'($urandom);
      apply();
      cycle();
      busy_n += int'(if_c.switch_busy[0]);
      check("s0.data_out", if_c.data_out, m_sel[2][0] ? m_ij[2][0] : m_func[2][0]);
    end
    check("s0.busy_cycles", W'(busy_n), '0);

    // Reset in the middle of a hold window.
    m_sel[0][0] = 1'b0;
    apply();
    for (int i = 0; i < 3; i++) cycle();
    m_sel[0][0] = 1'b1;
    apply();
    cycle();
    check("midrst.pre.switch_busy", W'(if_a.switch_busy), W'(1));
    #2;
    ijtag_reset = 1'b0;
    model_reset();
    #1;
    check_all();
    check("midrst.switch_busy", W'(if_a.switch_busy), '0);
    check("midrst.data_out", if_a.data_out, m_func[0][0]);
    m_func[0][0] = '0;
    drive();
    #1;
    ijtag_reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_ij[0][0] = W'($urandom);
      apply();
      cycle();
      check("midrst.hold.data_out", if_a.data_out, '0);
    end
    cycle();
    check("midrst.after.ijtag_active", W'(if_a.ijtag_active), W'(1));

    // Randomised traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        ijtag_reset = 1'b0;
        model_reset();
        #1;
        check_all();
        ijtag_reset = 1'b1;
      end
      for (int d = 0; d < 3; d++) begin
        for (int c = 0; c < 3; c++) begin
          if ($urandom_range(0, 5) == 0) m_sel[d][c] = ~m_sel[d][c];
          m_func[d][c] = W'($urandom);
          m_ij[d][c]   = W'($urandom);
        end
      end
      apply();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
